// File: rtl/clock_pkg.sv
// Shared constants and helpers for the runtime-ratio clock divider.
// The ratio clamp lives here so the divider and anything modelling it agree.
package clock_pkg;

    localparam int unsigned MIN_RATIO = 2;

    // Ratios below the minimum would leave no low or no high phase.
    function automatic int unsigned clamp_ratio(input int unsigned ratio);
        return (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N phase counter with a shadow ratio register.
// The shadow loads only at reset, clear or wrap, so a running period never changes length.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             sync_clear_i,
    input  logic [CNT_W-1:0] div_ratio_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic [CNT_W-1:0] ratio_next_o,
    output logic             update_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] ratio_load;
    logic             wrap;

    assign ratio_load = CNT_W'(clamp_ratio(32'(div_ratio_i)));
    assign wrap       = (cnt_q == ratio_q - CNT_W'(1));

    // Clear outranks enable; a held enable freezes both counter and shadow ratio.
    always_comb begin
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        update_o = 1'b0;
        if (sync_clear_i) begin
            cnt_d    = '0;
            ratio_d  = ratio_load;
            update_o = 1'b1;
        end else if (enable_i) begin
            update_o = 1'b1;
            if (wrap) begin
                cnt_d   = '0;
                ratio_d = ratio_load;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            ratio_q <= ratio_load;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign cnt_next_o   = cnt_d;
    assign ratio_next_o = ratio_d;

endmodule

// File: rtl/clock_divider_n.sv
// Divide-by-N clock generator: registered divided clock plus rise/fall strobes.
// Outputs are decoded from the counter's next state so every output is a plain flop.
module clock_divider_n
    import clock_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clear,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             out_clock,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] phase
);

    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] ratio_next;
    logic [CNT_W-1:0] half;
    logic             update;

    logic out_clock_q, out_clock_d;
    logic rise_tick_q, rise_tick_d;
    logic fall_tick_q, fall_tick_d;

    mod_n_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .enable_i    (enable),
        .sync_clear_i(sync_clear),
        .div_ratio_i (div_ratio),
        .cnt_o       (phase),
        .cnt_next_o  (cnt_next),
        .ratio_next_o(ratio_next),
        .update_o    (update)
    );

    // At a wrap ratio_next is the freshly loaded ratio, so the new period decodes correctly.
    assign half = ratio_next >> 1;

    always_comb begin
        out_clock_d = out_clock_q;
        rise_tick_d = rise_tick_q;
        fall_tick_d = fall_tick_q;
        if (update) begin
            out_clock_d = (cnt_next >= half);
            rise_tick_d = (cnt_next == half - CNT_W'(1));
            fall_tick_d = (cnt_next == ratio_next - CNT_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_clock_q <= 1'b0;
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
        end else begin
            out_clock_q <= out_clock_d;
            rise_tick_q <= rise_tick_d;
            fall_tick_q <= fall_tick_d;
        end
    end

    assign out_clock = out_clock_q;
    assign rise_tick = rise_tick_q;
    assign fall_tick = fall_tick_q;

endmodule

// File: tb/tb_clock_divider_n.sv
// Self-checking bench for clock_divider_n against a period-queue reference model.
// Each period is expanded into its list of expected cycles when it starts.
module tb_clock_divider_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sync_clear = 1'b0;
    logic [7:0] div_ratio = 8'd2;
    logic       out_clock;
    logic       rise_tick;
    logic       fall_tick;
    logic [7:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       oc;
        logic       rt;
        logic       ft;
        logic [7:0] ph;
    } obs_t;

    obs_t q[$];
    obs_t exp_o;
    obs_t got;

    always #5 clock = ~clock;

    clock_divider_n #(
        .CNT_W(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync_clear(sync_clear),
        .div_ratio (div_ratio),
        .out_clock (out_clock),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .phase     (phase)
    );

    assign got = '{oc: out_clock, rt: rise_tick, ft: fall_tick, ph: phase};

    // One full period: floor(N/2) low cycles, then the rest high.
    function automatic void gen_period(input logic [7:0] r);
        int unsigned n;
        int unsigned h;
        n = clock_pkg::clamp_ratio(32'(r));
        h = n / 2;
        for (int unsigned i = 0; i < n; i++) begin
            q.push_back('{oc: (i >= h), rt: (i == h - 1), ft: (i == n - 1), ph: 8'(i)});
        end
    endfunction

    task automatic tick(input logic rst, input logic clr, input logic en, input logic [7:0] r);
        reset      = rst;
        sync_clear = clr;
        enable     = en;
        div_ratio  = r;
        @(posedge clock);
        if (rst) begin
            q.delete();
            gen_period(r);
            void'(q.pop_front());
            exp_o = '0;
        end else if (clr) begin
            q.delete();
            gen_period(r);
            exp_o = q.pop_front();
        end else if (en) begin
            if (q.size() == 0) gen_period(r);
            exp_o = q.pop_front();
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, 8'd2);
        tick(1'b1, 1'b0, 1'b1, 8'd9);
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", got, obs_t'(0));
        end
    endtask

    task automatic test_div2();
        tick(1'b1, 1'b0, 1'b0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'd2);
            checks++;
            if (out_clock !== ((i % 2) == 0) || fall_tick !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL div2_toggle cycle %0d: got oc=%b ft=%b required %b", i, out_clock,
                         fall_tick, ((i % 2) == 0));
            end
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL div2_model cycle %0d: got %h required %h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_div5();
        logic [7:0] ph;
        tick(1'b1, 1'b0, 1'b0, 8'd5);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'd5);
            ph = 8'(i % 5);
            checks++;
            if (phase !== ph || out_clock !== (ph >= 2) || rise_tick !== (ph == 1) ||
                fall_tick !== (ph == 4)) begin
                errors++;
                $display("FAIL div5_sequence cycle %0d: got %h required ph=%0d", i, got, ph);
            end
        end
    endtask

    task automatic test_ratio_change();
        tick(1'b1, 1'b0, 1'b0, 8'd4);
        tick(1'b0, 1'b0, 1'b1, 8'd4);
        // Now at phase 1 of a 4-cycle period; request 6 mid-period.
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 8'd6);
        checks++;
        if (phase !== 8'd3 || fall_tick !== 1'b1) begin
            errors++;
            $display("FAIL ratio_change_old_period: got %h required ph=3 ft=1", got);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'd6);
            checks++;
            if (phase !== 8'(i % 6) || out_clock !== ((i % 6) >= 3) || got !== exp_o) begin
                errors++;
                $display("FAIL ratio_change_new_period %0d: got %h required %h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_clamp();
        int lo;
        int hi;
        for (int r = 0; r < 2; r++) begin
            tick(1'b1, 1'b0, 1'b0, 8'(r));
            for (int i = 0; i < 6; i++) begin
                tick(1'b0, 1'b0, 1'b1, 8'(r));
                checks++;
                if (out_clock !== ((i % 2) == 0) || phase !== 8'((i + 1) % 2)) begin
                    errors++;
                    $display("FAIL clamp_ratio%0d cycle %0d: got %h required oc=%b", r, i, got,
                             ((i % 2) == 0));
                end
            end
        end
        tick(1'b1, 1'b0, 1'b0, 8'd255);
        lo = 0;
        hi = 0;
        for (int i = 0; i < 255; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'd255);
            if (out_clock === 1'b1) hi++;
            else lo++;
        end
        checks++;
        if (lo != 127 || hi != 128) begin
            errors++;
            $display("FAIL ratio255_duty: got lo=%0d hi=%0d required lo=127 hi=128", lo, hi);
        end
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL ratio255_model: got %h required %h", got, exp_o);
        end
    endtask

    task automatic test_enable_freeze();
        tick(1'b1, 1'b0, 1'b0, 8'd6);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 8'd6);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'(i + 2));
            checks++;
            if (got !== obs_t'{oc: 1'b1, rt: 1'b0, ft: 1'b0, ph: 8'd4}) begin
                errors++;
                $display("FAIL enable_freeze %0d: got %h required ph=4 oc=1", i, got);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 8'd6);
        checks++;
        if (got !== obs_t'{oc: 1'b1, rt: 1'b0, ft: 1'b1, ph: 8'd5}) begin
            errors++;
            $display("FAIL enable_resume: got %h required ph=5 oc=1 ft=1", got);
        end
    endtask

    task automatic test_sync_clear();
        tick(1'b1, 1'b0, 1'b0, 8'd7);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 8'd7);
        tick(1'b0, 1'b1, 1'b1, 8'd7);
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL sync_clear: got %h required all zero", got);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 8'd7);
        checks++;
        if (phase !== 8'd3 || out_clock !== 1'b1) begin
            errors++;
            $display("FAIL sync_clear_resume: got %h required ph=3 oc=1", got);
        end
        tick(1'b1, 1'b0, 1'b1, 8'd7);
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_mid_period: got %h required all zero", got);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 8'd2);
        // Clear while disabled still restarts; new ratio 3 gives half 1, so rise_tick is set.
        tick(1'b0, 1'b1, 1'b0, 8'd3);
        checks++;
        if (got !== obs_t'{oc: 1'b0, rt: 1'b1, ft: 1'b0, ph: 8'd0}) begin
            errors++;
            $display("FAIL sync_clear_disabled: got %h required ph=0 rt=1", got);
        end
    endtask

    task automatic test_random();
        logic       rst;
        logic       clr;
        logic       en;
        logic [7:0] r;
        tick(1'b1, 1'b0, 1'b0, 8'd3);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 12));
            tick(rst, clr, en, r);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL random cycle %0d: got %h required %h", i, got, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div5();
        test_ratio_change();
        test_clamp();
        test_enable_freeze();
        test_sync_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
